// File: rtl/operand_fetch_seq_pkg.sv
// Shared widths, FSM state encoding and index helper for the operand-fetch sequencer.
package ofs_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int RF_AW  = 8;
    localparam int RF_DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_B  = 3'd2,
        CAP_B = 3'd3,
        DONE  = 3'd4,
        WRITE = 3'd5
    } state_t;

    // Register indices are narrower than the file's address port; upper bits are always zero.
    function automatic logic [RF_AW-1:0] rf_index(input logic [ADDR_W-1:0] idx);
        return {{(RF_AW-ADDR_W){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/operand_fetch_seq_if.sv
// Handshake and register-file port bundle between upstream/execute logic and the sequencer.
interface ofs_if;
    import ofs_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_dst;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [RF_AW-1:0]  rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_we;
    logic [DATA_W-1:0] rf_rdata;

    modport slave (
        input  req_valid, src_a, src_b, wb_valid, wb_dst, wb_data, out_ready, rf_rdata,
        output req_ready, wb_ready, out_valid, op_a, op_b, rf_addr, rf_wdata, rf_we
    );

    modport master (
        output req_valid, src_a, src_b, wb_valid, wb_dst, wb_data, out_ready, rf_rdata,
        input  req_ready, wb_ready, out_valid, op_a, op_b, rf_addr, rf_wdata, rf_we
    );

endinterface

// File: rtl/shiftregs.sv
// 32x8 register file: writes commit on negedge while enable is high; data_out registered at posedge.
// Latency: one posedge from address to data_out. No backpressure; always accepts.
module shiftregs
    import ofs_pkg::*;
(
    input  logic              clk,
    input  logic [RF_AW-1:0]  address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              enable,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] r_mem [RF_DEPTH];
    logic              w_unused;

    assign w_unused = ^address[RF_AW-1:ADDR_W];

    always_ff @(negedge clk) begin
        if (enable) begin
            r_mem[address[ADDR_W-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        data_out <= r_mem[address[ADDR_W-1:0]];
    end

endmodule

// File: rtl/operand_fetch_seq.sv
// Sequences operand fetches and write-backs onto a single-port register file.
// Latency: operands valid 3 cycles after accept; write-back occupies one cycle.
// Backpressure: operands held until out_ready; no new request accepted while busy.
module operand_fetch_seq
    import ofs_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    ofs_if.slave bus
);

    state_t            r_state,    w_nxt_state;
    logic [ADDR_W-1:0] r_src_b,    w_nxt_src_b;
    logic [RF_AW-1:0]  r_rf_addr,  w_nxt_rf_addr;
    logic [DATA_W-1:0] r_rf_wdata, w_nxt_rf_wdata;
    logic              r_rf_we,    w_nxt_rf_we;
    logic [DATA_W-1:0] r_op_a,     w_nxt_op_a;
    logic [DATA_W-1:0] r_op_b,     w_nxt_op_b;
    logic              r_out_valid, w_nxt_out_valid;

    // Write-back wins over fetch when both are pending in IDLE.
    assign bus.wb_ready  = (r_state == IDLE);
    assign bus.req_ready = (r_state == IDLE) && !bus.wb_valid;

    assign bus.rf_addr   = r_rf_addr;
    assign bus.rf_wdata  = r_rf_wdata;
    assign bus.rf_we     = r_rf_we;
    assign bus.op_a      = r_op_a;
    assign bus.op_b      = r_op_b;
    assign bus.out_valid = r_out_valid;

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_src_b     = r_src_b;
        w_nxt_rf_addr   = r_rf_addr;
        w_nxt_rf_wdata  = r_rf_wdata;
        w_nxt_rf_we     = 1'b0;
        w_nxt_op_a      = r_op_a;
        w_nxt_op_b      = r_op_b;
        w_nxt_out_valid = r_out_valid;

        case (r_state)
            IDLE: begin
                if (bus.wb_valid) begin
                    w_nxt_state    = WRITE;
                    w_nxt_rf_addr  = rf_index(bus.wb_dst);
                    w_nxt_rf_wdata = bus.wb_data;
                    w_nxt_rf_we    = 1'b1;
                end else if (bus.req_valid) begin
                    w_nxt_state   = RD_A;
                    w_nxt_rf_addr = rf_index(bus.src_a);
                    w_nxt_src_b   = bus.src_b;
                end
            end
            RD_A: begin
                w_nxt_state   = RD_B;
                w_nxt_rf_addr = rf_index(r_src_b);
            end
            // The file's registered output lags the address by one posedge.
            RD_B: begin
                w_nxt_state = CAP_B;
                w_nxt_op_a  = bus.rf_rdata;
            end
            CAP_B: begin
                w_nxt_state     = DONE;
                w_nxt_op_b      = bus.rf_rdata;
                w_nxt_out_valid = 1'b1;
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_nxt_state     = IDLE;
                    w_nxt_out_valid = 1'b0;
                end
            end
            WRITE: begin
                w_nxt_state = IDLE;
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_src_b     <= '0;
            r_rf_addr   <= '0;
            r_rf_wdata  <= '0;
            r_rf_we     <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_src_b     <= w_nxt_src_b;
            r_rf_addr   <= w_nxt_rf_addr;
            r_rf_wdata  <= w_nxt_rf_wdata;
            r_rf_we     <= w_nxt_rf_we;
            r_op_a      <= w_nxt_op_a;
            r_op_b      <= w_nxt_op_b;
            r_out_valid <= w_nxt_out_valid;
        end
    end

endmodule
